// File: rtl/dmac_slave_desc_if.sv
// CPU-side register bus between the host and the DMAC slave descriptor block.
interface dmac_slave_desc_if #(parameter int DATA_W = 32);
  logic              S_sel;
  logic              S_wr;
  logic [7:0]        S_address;
  logic [DATA_W-1:0] S_din;
  logic [DATA_W-1:0] S_dout;

  modport master (output S_sel, output S_wr, output S_address, output S_din, input S_dout);
  modport slave  (input S_sel, input S_wr, input S_address, input S_din, output S_dout);
endinterface

// File: rtl/dmac_slave_desc.sv
// DMAC bus-slave register file, descriptor FIFO and start/clear control.
// Optional feature: define DMAC_INTERRUPT_EN for the INTEN register and interrupt output.
module dmac_slave_desc #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  dmac_slave_desc_if.slave  bus,
  input  logic              op_done,
  input  logic              rd_en,
  output logic              op_start,
  output logic              op_clear,
  output logic [DATA_W-1:0] opmode,
  output logic [DATA_W-1:0] sc_addr,
  output logic [DATA_W-1:0] ds_addr,
  output logic [DATA_W-1:0] data_size,
  output logic [3:0]        data_count,
  output logic              interrupt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0] A_START  = 8'h00;
  localparam logic [7:0] A_INTR   = 8'h01;
  localparam logic [7:0] A_INTEN  = 8'h02;
  localparam logic [7:0] A_SRC    = 8'h03;
  localparam logic [7:0] A_DST    = 8'h04;
  localparam logic [7:0] A_SIZE   = 8'h05;
  localparam logic [7:0] A_PUSH   = 8'h06;
  localparam logic [7:0] A_MODE   = 8'h07;
  localparam logic [7:0] A_CLEAR  = 8'h08;
  localparam logic [7:0] A_DCOUNT = 8'h09;

  logic [1:0]        state_r, state_nxt_s;
  logic              done_flag_r, op_start_r, op_clear_r, interrupt_r, inten_r;
  logic [DATA_W-1:0] src_r, dst_r, size_r, s_dout_r, rdata_s;
  logic [1:0]        mode_r;
  logic [DATA_W-1:0] fifo_src_r  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_dst_r  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_size_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [3:0]        count_r;
  logic [DATA_W-1:0] sc_addr_r, ds_addr_r, data_size_r;
  logic              wr_s, rd_s, wr_bit0_s, idle_s, push_s, pop_s, start_s, clear_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : p + {{(PTR_W-1){1'b0}}, 1'b1};
  endfunction

  // Access decode; FIFO fullness and emptiness are judged on pre-edge count.
  always_comb begin
    wr_s      = bus.S_sel & bus.S_wr;
    rd_s      = bus.S_sel & ~bus.S_wr;
    wr_bit0_s = wr_s & bus.S_din[0];
    idle_s    = (state_r == ST_IDLE);
    push_s    = wr_bit0_s & (bus.S_address == A_PUSH) & idle_s & (count_r < 4'(FIFO_DEPTH));
    pop_s     = rd_en & (count_r != 4'd0);
    start_s   = wr_bit0_s & (bus.S_address == A_START) & idle_s & (count_r != 4'd0);
    clear_s   = wr_bit0_s & (bus.S_address == A_CLEAR) & (state_r == ST_DONE);
  end

  // Control FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: if (start_s) state_nxt_s = ST_BUSY; else state_nxt_s = ST_IDLE;
      ST_BUSY: if (op_done) state_nxt_s = ST_DONE; else state_nxt_s = ST_BUSY;
      ST_DONE: if (clear_s) state_nxt_s = ST_IDLE; else state_nxt_s = ST_DONE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state, done flag and the single-cycle start/clear pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      done_flag_r <= 1'b0;
      op_start_r  <= 1'b0;
      op_clear_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      op_start_r <= start_s;
      op_clear_r <= clear_s;
      if (clear_s)
        done_flag_r <= 1'b0;
      else if ((state_r == ST_BUSY) && op_done)
        done_flag_r <= 1'b1;
      else
        done_flag_r <= done_flag_r;
    end
  end

  // Descriptor staging registers; frozen outside IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_r  <= {DATA_W{1'b0}};
      dst_r  <= {DATA_W{1'b0}};
      size_r <= {DATA_W{1'b0}};
      mode_r <= 2'b00;
    end else if (wr_s && idle_s) begin
      case (bus.S_address)
        A_SRC:   src_r  <= bus.S_din;
        A_DST:   dst_r  <= bus.S_din;
        A_SIZE:  size_r <= bus.S_din;
        A_MODE:  mode_r <= bus.S_din[1:0];
        default: ;
      endcase
    end
  end

  // Descriptor FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_src_r[i]  <= {DATA_W{1'b0}};
        fifo_dst_r[i]  <= {DATA_W{1'b0}};
        fifo_size_r[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= 4'd0;
    end else begin
      if (push_s) begin
        fifo_src_r[wr_ptr_r]  <= src_r;
        fifo_dst_r[wr_ptr_r]  <= dst_r;
        fifo_size_r[wr_ptr_r] <= size_r;
        wr_ptr_r              <= ptr_inc(wr_ptr_r);
      end
      if (pop_s)
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 4'd1;
        2'b01:   count_r <= count_r - 4'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head-of-FIFO outputs hold their value until the next successful pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sc_addr_r   <= {DATA_W{1'b0}};
      ds_addr_r   <= {DATA_W{1'b0}};
      data_size_r <= {DATA_W{1'b0}};
    end else if (pop_s) begin
      sc_addr_r   <= fifo_src_r[rd_ptr_r];
      ds_addr_r   <= fifo_dst_r[rd_ptr_r];
      data_size_r <= fifo_size_r[rd_ptr_r];
    end
  end

`ifdef DMAC_INTERRUPT_EN
  // Interrupt enable register and registered interrupt request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inten_r     <= 1'b0;
      interrupt_r <= 1'b0;
    end else begin
      interrupt_r <= done_flag_r & inten_r;
      if (wr_s && (bus.S_address == A_INTEN))
        inten_r <= bus.S_din[0];
    end
  end
`else
  assign inten_r     = 1'b0;
  assign interrupt_r = 1'b0;
`endif

  // Read data mux; write-only and unmapped addresses return zero.
  always_comb begin
    rdata_s = {DATA_W{1'b0}};
    case (bus.S_address)
      A_INTR:   rdata_s = {{(DATA_W-1){1'b0}}, done_flag_r};
      A_INTEN:  rdata_s = {{(DATA_W-1){1'b0}}, inten_r};
      A_SRC:    rdata_s = src_r;
      A_DST:    rdata_s = dst_r;
      A_SIZE:   rdata_s = size_r;
      A_MODE:   rdata_s = {{(DATA_W-2){1'b0}}, mode_r};
      A_DCOUNT: rdata_s = {{(DATA_W-4){1'b0}}, count_r};
      default:  rdata_s = {DATA_W{1'b0}};
    endcase
  end

  // Registered read data, zero in any cycle without a read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      s_dout_r <= {DATA_W{1'b0}};
    else if (rd_s)
      s_dout_r <= rdata_s;
    else
      s_dout_r <= {DATA_W{1'b0}};
  end

  assign bus.S_dout = s_dout_r;
  assign op_start   = op_start_r;
  assign op_clear   = op_clear_r;
  assign opmode     = {{(DATA_W-2){1'b0}}, mode_r};
  assign sc_addr    = sc_addr_r;
  assign ds_addr    = ds_addr_r;
  assign data_size  = data_size_r;
  assign data_count = count_r;
  assign interrupt  = interrupt_r;

endmodule
